fpu_mul: RTL

//  Iterative IEEE-754 multiplier for the FPU; the companion of fpuDiv, with an

---
 rtl/fpu_mul.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul.sv
// fpu_mul: iterative fp16 multiplier (shift-add significands, round-to-nearest-even, FTZ).
// Optional macro FPU_MUL_EARLY_OUT_EN lets special operands bypass MULT/NORM/ROUND.
package fpu_mul_pkg;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic divByZero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;
endpackage

module fpu_mul
    import fpu_mul_pkg::*;
#(
    parameter type FP_T = fp16_t
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  FP_T           fpuIn1,
    input  FP_T           fpuIn2,
    output FP_T           fpuOut,
    output logic          done,
    output condCode_t     condCodes,
    output opStatusFlag_t opStatusFlags
);

    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned SEXP_W = EXP_W + 2;
    localparam int unsigned CNT_W  = $clog2(MANT_W);
    localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [SEXP_W-1:0] EXP_MAX = SEXP_W'((1 << EXP_W) - 1);
    localparam logic signed [SEXP_W-1:0] EXP_ONE = SEXP_W'(1);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

    state_t                    state_q;
    FP_T                       a_q;
    FP_T                       b_q;
    logic                      sign_q;
    logic                      nan_q;
    logic                      inf_q;
    logic                      zero_q;
    logic [MANT_W-1:0]         mcand_q;
    logic [MANT_W-1:0]         mplier_q;
    logic [PROD_W-1:0]         acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [SEXP_W-1:0]  exp_q;
    logic [MANT_W-1:0]         mant_q;
    logic                      guard_q;
    logic                      sticky_q;
    logic                      inexact_q;

    // Operand classification on the captured inputs
    logic a_zero_c, b_zero_c, a_max_c, b_max_c, nan_c, inf_c, zero_c;
    always_comb begin
        a_zero_c = (a_q.exp == '0);
        b_zero_c = (b_q.exp == '0);
        a_max_c  = (a_q.exp == '1);
        b_max_c  = (b_q.exp == '1);
        nan_c    = (a_max_c && a_q.frac != '0) || (b_max_c && b_q.frac != '0);
        inf_c    = (a_max_c && a_q.frac == '0) || (b_max_c && b_q.frac == '0);
        zero_c   = a_zero_c || b_zero_c;
    end

`ifdef FPU_MUL_EARLY_OUT_EN
    logic special_c;
    always_comb begin
        special_c = nan_c || inf_c || zero_c;
    end
`endif

    // One shift-add step: upper half of the accumulator plus optional multiplicand
    logic [MANT_W:0] sum_c;
    always_comb begin
        sum_c = {1'b0, acc_q[PROD_W-1:MANT_W]}
              + (mplier_q[0] ? {1'b0, mcand_q} : (MANT_W + 1)'(0));
    end

    // Nearest-even increment; carry-out lands in the top bit
    logic            round_up_c;
    logic [MANT_W:0] rnd_c;
    always_comb begin
        round_up_c = guard_q & (sticky_q | mant_q[0]);
        rnd_c      = {1'b0, mant_q} + (MANT_W + 1)'(round_up_c);
    end

    // Final result selection in exception priority order
    FP_T           res_c;
    opStatusFlag_t flags_c;
    always_comb begin
        res_c   = '0;
        flags_c = '0;
        if (nan_q || (inf_q && zero_q)) begin
            res_c.exp             = '1;
            res_c.frac[FRAC_W-1]  = 1'b1;
            flags_c.invalid       = !nan_q;
        end else if (inf_q) begin
            res_c.sign = sign_q;
            res_c.exp  = '1;
        end else if (zero_q) begin
            res_c.sign = sign_q;
        end else if (exp_q >= EXP_MAX) begin
            res_c.sign       = sign_q;
            res_c.exp        = '1;
            flags_c.overflow = 1'b1;
            flags_c.inexact  = 1'b1;
        end else if (exp_q <= SEXP_W'(0)) begin
            res_c.sign        = sign_q;
            flags_c.underflow = 1'b1;
            flags_c.inexact   = 1'b1;
        end else begin
            res_c.sign      = sign_q;
            res_c.exp       = exp_q[EXP_W-1:0];
            res_c.frac      = mant_q[FRAC_W-1:0];
            flags_c.inexact = inexact_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sign_q        <= 1'b0;
            nan_q         <= 1'b0;
            inf_q         <= 1'b0;
            zero_q        <= 1'b0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            exp_q         <= '0;
            mant_q        <= '0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            inexact_q     <= 1'b0;
            fpuOut        <= '0;
            done          <= 1'b0;
            condCodes     <= '0;
            opStatusFlags <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= fpuIn1;
                        b_q     <= fpuIn2;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q    <= a_q.sign ^ b_q.sign;
                    nan_q     <= nan_c;
                    inf_q     <= inf_c;
                    zero_q    <= zero_c;
                    mcand_q   <= {1'b1, a_q.frac};
                    mplier_q  <= {1'b1, b_q.frac};
                    acc_q     <= '0;
                    cnt_q     <= CNT_W'(MANT_W - 1);
                    inexact_q <= 1'b0;
                    exp_q     <= $signed(SEXP_W'(a_q.exp) + SEXP_W'(b_q.exp) - SEXP_W'(BIAS));
`ifdef FPU_MUL_EARLY_OUT_EN
                    state_q   <= special_c ? DONE : MULT;
`else
                    state_q   <= MULT;
`endif
                end
                MULT: begin
                    acc_q    <= {sum_c, acc_q[MANT_W-1:1]};
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    // Product in [2,4) keeps one more bit of the top half
                    if (acc_q[PROD_W-1]) begin
                        mant_q   <= acc_q[PROD_W-1 -: MANT_W];
                        guard_q  <= acc_q[MANT_W-1];
                        sticky_q <= |acc_q[MANT_W-2:0];
                        exp_q    <= exp_q + EXP_ONE;
                    end else begin
                        mant_q   <= acc_q[PROD_W-2 -: MANT_W];
                        guard_q  <= acc_q[MANT_W-2];
                        sticky_q <= |acc_q[MANT_W-3:0];
                    end
                    state_q <= ROUND;
                end
                ROUND: begin
                    if (rnd_c[MANT_W]) begin
                        mant_q <= rnd_c[MANT_W:1];
                        exp_q  <= exp_q + EXP_ONE;
                    end else begin
                        mant_q <= rnd_c[MANT_W-1:0];
                    end
                    inexact_q <= guard_q | sticky_q;
                    state_q   <= DONE;
                end
                DONE: begin
                    fpuOut        <= res_c;
                    opStatusFlags <= flags_c;
                    condCodes.n   <= res_c.sign;
                    condCodes.z   <= (res_c.exp == '0) && (res_c.frac == '0);
                    condCodes.v   <= 1'b0;
                    condCodes.c   <= 1'b0;
                    done          <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
